// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch front end: bus layout,
// default reset vector, exception bit index and fetch FSM encodings.
package if_fetch_ctrl_pkg;

    localparam int          EBUS_W_DFLT    = 16;
    localparam int          IFREG_BUS_LEN  = EBUS_W_DFLT + 64;
    localparam int          EBUS_ADEF_DFLT = 0;
    localparam logic [31:0] RESET_PC_DFLT  = 32'h1c000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    // A fetch target that is not word aligned raises ADEF instead of a request.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_inst_buf.sv
// One-entry instruction buffer between the SRAM response and ID.
// Only the valid flag is reset; the payload is meaningful only while valid.
module if_inst_buf #(
    parameter int EBUS_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill,
    input  logic              drain,
    input  logic              flush,
    input  logic [31:0]       fill_inst,
    input  logic [31:0]       fill_pc,
    input  logic [EBUS_W-1:0] fill_ebus,
    output logic              buf_valid,
    output logic [EBUS_W+63:0] buf_bus
);

    logic [EBUS_W-1:0] ebus_q;
    logic [31:0]       inst_q;
    logic [31:0]       pc_q;

    // Valid flag: a fill in the same cycle as a drain/flush keeps the entry occupied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
        end else if (fill) begin
            buf_valid <= 1'b1;
        end else if (drain || flush) begin
            buf_valid <= 1'b0;
        end
    end

    // Payload capture on fill.
    always_ff @(posedge clk) begin
        if (fill) begin
            ebus_q <= fill_ebus;
            inst_q <= fill_inst;
            pc_q   <= fill_pc;
        end
    end

    assign buf_bus = {ebus_q, inst_q, pc_q};

endmodule

// File: rtl/if_fetch_ctrl.sv
// Pre-IF/IF fetch sequencer for an SRAM-like instruction port. Owns the
// fetch PC, keeps at most one transaction outstanding, drops responses that
// a redirect made stale, and holds the returned instruction until ID takes it.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DFLT,
    parameter int          EBUS_W    = EBUS_W_DFLT,
    parameter int          EBUS_ADEF = EBUS_ADEF_DFLT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               ID_allow_in,
    output logic               inst_sram_req,
    output logic               inst_sram_wr,
    output logic [1:0]         inst_sram_size,
    output logic [3:0]         inst_sram_wstrb,
    output logic [31:0]        inst_sram_wdata,
    output logic [31:0]        inst_sram_addr,
    input  logic               inst_sram_addr_ok,
    input  logic               inst_sram_data_ok,
    input  logic [31:0]        inst_sram_rdata,
    output logic               IFreg_valid,
    output logic [EBUS_W+63:0] IFreg_bus
);

    fetch_state_t      state, state_nxt;
    logic [31:0]       fetch_pc, fetch_pc_nxt;
    logic [31:0]       pend_pc, pend_pc_nxt;
    logic              cancel, cancel_nxt;

    logic              go_req;
    logic [31:0]       go_pc;
    logic              buf_fill, buf_drain, buf_flush;
    logic [31:0]       fill_inst, fill_pc;
    logic [EBUS_W-1:0] fill_ebus;
    logic              buf_valid;

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    // Control state: FSM, fetch PC, pending redirect target and cancel flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            pend_pc  <= RESET_PC;
            cancel   <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            pend_pc  <= pend_pc_nxt;
            cancel   <= cancel_nxt;
        end
    end

    // Next-state, request and buffer control. Every path that starts a new
    // fetch sets go_req/go_pc; the common tail below turns that into either a
    // request or a direct ADEF load of the buffer.
    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        pend_pc_nxt    = pend_pc;
        cancel_nxt     = cancel;
        go_req         = 1'b0;
        go_pc          = fetch_pc;
        buf_fill       = 1'b0;
        buf_drain      = 1'b0;
        buf_flush      = 1'b0;
        fill_inst      = inst_sram_rdata;
        fill_pc        = fetch_pc;
        fill_ebus      = '0;
        inst_sram_req  = 1'b0;
        inst_sram_addr = fetch_pc;

        case (state)
            ST_IDLE: begin
                go_req = 1'b1;
                go_pc  = redirect_valid ? redirect_pc : fetch_pc;
            end
            ST_REQ: begin
                // Request stays stable; a redirect only records its target.
                inst_sram_req = 1'b1;
                if (redirect_valid) begin
                    cancel_nxt  = 1'b1;
                    pend_pc_nxt = redirect_pc;
                end
                if (inst_sram_addr_ok) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (redirect_valid) begin
                        go_req     = 1'b1;
                        go_pc      = redirect_pc;
                        cancel_nxt = 1'b0;
                    end else if (cancel) begin
                        go_req     = 1'b1;
                        go_pc      = pend_pc;
                        cancel_nxt = 1'b0;
                    end else begin
                        buf_fill  = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    cancel_nxt  = 1'b1;
                    pend_pc_nxt = redirect_pc;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    buf_flush = 1'b1;
                    go_req    = 1'b1;
                    go_pc     = redirect_pc;
                end else if (ID_allow_in) begin
                    // Drain and request the next word in the same cycle.
                    buf_drain = 1'b1;
                    go_req    = 1'b1;
                    go_pc     = fetch_pc + 32'd4;
                    if (!pc_misaligned(go_pc)) begin
                        inst_sram_req  = 1'b1;
                        inst_sram_addr = go_pc;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (go_req) begin
            fetch_pc_nxt = go_pc;
            if (pc_misaligned(go_pc)) begin
                buf_fill             = 1'b1;
                fill_inst            = 32'h0;
                fill_pc              = go_pc;
                fill_ebus[EBUS_ADEF] = 1'b1;
                state_nxt            = ST_HOLD;
            end else if (inst_sram_req && inst_sram_addr_ok) begin
                state_nxt = ST_WAIT;
            end else begin
                state_nxt = ST_REQ;
            end
        end
    end

    if_inst_buf #(
        .EBUS_W (EBUS_W)
    ) u_inst_buf (
        .clk       (clk),
        .reset     (reset),
        .fill      (buf_fill),
        .drain     (buf_drain),
        .flush     (buf_flush),
        .fill_inst (fill_inst),
        .fill_pc   (fill_pc),
        .fill_ebus (fill_ebus),
        .buf_valid (buf_valid),
        .buf_bus   (IFreg_bus)
    );

    assign IFreg_valid = buf_valid & ~redirect_valid;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed testbench for if_fetch_ctrl with a hand-off scoreboard.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ID_allow_in;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        IFreg_valid;
    logic [79:0] IFreg_bus;

    int tests = 0;
    int fails = 0;
    logic [79:0] sb[$];

    if_fetch_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .ID_allow_in       (ID_allow_in),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .IFreg_valid       (IFreg_valid),
        .IFreg_bus         (IFreg_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] ent(input logic adef, input logic [31:0] inst, input logic [31:0] pc);
        return {15'h0, adef, inst, pc};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs, let outputs settle, and score any hand-off.
    task automatic drive(input logic ao, input logic dok, input logic [31:0] rd,
                         input logic alw, input logic rv, input logic [31:0] rpc);
        logic [79:0] e;
        inst_sram_addr_ok = ao;
        inst_sram_data_ok = dok;
        inst_sram_rdata   = rd;
        ID_allow_in       = alw;
        redirect_valid    = rv;
        redirect_pc       = rpc;
        #1;
        if (IFreg_valid && ID_allow_in) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL handoff_unexpected observed=%h expected=none", IFreg_bus);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("handoff", IFreg_bus, e);
            end
        end
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, inst_sram_req, r);
        if (r) chk({tag, "_addr"}, inst_sram_addr, a);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_req", inst_sram_req, 0);
        chk("rst_valid", IFreg_valid, 0);
        chk("rst_wr", inst_sram_wr, 0);
        chk("rst_size", inst_sram_size, 2'b10);
        chk("rst_wstrb", inst_sram_wstrb, 0);
        chk("rst_wdata", inst_sram_wdata, 0);

        // Basic fetch with back-to-back drain request
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk_req("idle", 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk_req("t1_req", 1, 32'h1c000000);
        tick();
        drive(0, 1, 32'h02800c0c, 0, 0, 0);
        sb.push_back(ent(0, 32'h02800c0c, 32'h1c000000));
        chk_req("t1_wait", 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        chk_req("t1_b2b", 1, 32'h1c000004);
        tick();

        // ID stall for 5 cycles
        drive(1, 0, 0, 0, 0, 0);
        chk("t2_valid_lo", IFreg_valid, 0);
        chk_req("t2_req", 1, 32'h1c000004);
        tick();
        drive(0, 1, 32'h02800421, 0, 0, 0);
        sb.push_back(ent(0, 32'h02800421, 32'h1c000004));
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("t2_stall_valid", IFreg_valid, 1);
            chk("t2_stall_bus", IFreg_bus, ent(0, 32'h02800421, 32'h1c000004));
            chk("t2_stall_req", inst_sram_req, 0);
            tick();
        end
        drive(1, 0, 0, 1, 0, 0);
        chk_req("t2_release", 1, 32'h1c000008);
        tick();

        // Redirect in WAIT, stale response dropped
        drive(0, 0, 0, 0, 1, 32'h1c008000);
        chk("t3_valid", IFreg_valid, 0);
        chk("t3_req", inst_sram_req, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("t3_wait_req", inst_sram_req, 0);
            tick();
        end
        drive(0, 1, 32'hdeadbeef, 1, 0, 0);
        chk("t3_drop_valid", IFreg_valid, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        chk("t3_after_valid", IFreg_valid, 0);
        chk_req("t3_next", 1, 32'h1c008000);
        tick();

        // Redirect while addr_ok is withheld
        drive(0, 0, 0, 0, 1, 32'h1c000100);
        chk_req("t4_hold0", 1, 32'h1c008000);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk_req("t4_hold", 1, 32'h1c008000);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0);
        chk_req("t4_accept", 1, 32'h1c008000);
        tick();
        drive(0, 1, 32'h11111111, 0, 0, 0);
        chk("t4_drop_valid", IFreg_valid, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("t4_after_valid", IFreg_valid, 0);
        chk_req("t4_next", 1, 32'h1c000100);
        tick();
        drive(0, 1, 32'h12345678, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t4_buf_valid", IFreg_valid, 1);
        chk("t4_buf_bus", IFreg_bus, ent(0, 32'h12345678, 32'h1c000100));
        tick();

        // ADEF on misaligned redirect from HOLD, and on chained drain
        drive(0, 0, 0, 0, 1, 32'h1c000102);
        chk("t5_mask_valid", IFreg_valid, 0);
        chk("t5_req0", inst_sram_req, 0);
        sb.push_back(ent(1, 32'h0, 32'h1c000102));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_req1", inst_sram_req, 0);
        chk("t5_valid", IFreg_valid, 1);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        chk("t5_req2", inst_sram_req, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_chain_bus", IFreg_bus, ent(1, 32'h0, 32'h1c000106));
        chk("t5_chain_valid", IFreg_valid, 1);
        chk("t5_req3", inst_sram_req, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h1c000200);
        chk("t5_flush_mask", IFreg_valid, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk_req("t5_recover", 1, 32'h1c000200);
        tick();

        // PC wrap
        drive(0, 1, 32'haaaa0001, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'hfffffffc);
        chk("wrap_mask", IFreg_valid, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk_req("wrap_req", 1, 32'hfffffffc);
        tick();
        drive(0, 1, 32'hbbbb0002, 0, 0, 0);
        sb.push_back(ent(0, 32'hbbbb0002, 32'hfffffffc));
        tick();
        drive(0, 0, 0, 1, 0, 0);
        chk_req("wrap_zero", 1, 32'h0);
        tick();

        // Reset during WAIT
        drive(1, 0, 0, 0, 0, 0);
        chk_req("t6_req", 1, 32'h0);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_rst_req", inst_sram_req, 0);
        chk("t6_rst_valid", IFreg_valid, 0);
        tick();
        drive(0, 1, 32'hcccc0003, 0, 0, 0);
        chk("t6_rst_req2", inst_sram_req, 0);
        tick();
        reset = 1'b0;
        drive(0, 1, 32'hcccc0004, 0, 0, 0);
        chk("t6_idle_req", inst_sram_req, 0);
        chk("t6_idle_valid", IFreg_valid, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("t6_restart_valid", IFreg_valid, 0);
        chk_req("t6_restart", 1, 32'h1c000000);
        tick();
        drive(0, 1, 32'habcdef01, 0, 0, 0);
        sb.push_back(ent(0, 32'habcdef01, 32'h1c000000));
        tick();
        drive(0, 0, 0, 1, 0, 0);
        chk_req("t6_next", 1, 32'h1c000004);
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Pre-IF/IF fetch sequencer for the SRAM-like instruction port (req / addr_ok / data_ok).
- Owns the fetch PC and issues one instruction request at a time.
- Cancels in-flight fetches on redirect (exception entry, ertn, branch) and buffers the returned instruction until ID accepts it.
- Replaces the always-ready, single-cycle SRAM assumption in the front end. Sits between the branch/exception redirect sources and the ID stage.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- EBUS_W, 16, width of the one-hot exception bus passed to ID.
- EBUS_ADEF, 0, bit index of ADEF in the exception bus.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- redirect_valid  in  1  flush request from WB exception, ertn or ID branch
- redirect_pc  in  32  target PC for redirect_valid
- ID_allow_in  in  1  ID accepts an instruction this cycle
- inst_sram_req  out  1  request valid
- inst_sram_wr  out  1  tied 0
- inst_sram_size  out  2  tied 2'b10
- inst_sram_wstrb  out  4  tied 0
- inst_sram_wdata  out  32  tied 0
- inst_sram_addr  out  32  request address
- inst_sram_addr_ok  in  1  address handshake
- inst_sram_data_ok  in  1  read data valid
- inst_sram_rdata  in  32  read data
- IFreg_valid  out  1  instruction/exception valid toward ID
- IFreg_bus  out  EBUS_W+64  {ebus, inst, pc}

Behaviour:
- Reset (async): state=IDLE, fetch_pc=RESET_PC, cancel=0, buf_valid=0, IFreg_valid=0, inst_sram_req=0.
- States:
  - IDLE: no request.
  - REQ: req=1, addr=fetch_pc; addr and req are held stable until addr_ok.
  - WAIT: waiting for data_ok.
  - HOLD: buffer full, ID stalled.
- IDLE→REQ the first cycle after reset deasserts.
- REQ→WAIT on addr_ok.
- WAIT on data_ok:
  - If cancel=0: latch rdata with fetch_pc into the buffer, set buf_valid, go to HOLD.
  - If cancel=1: drop the data, clear cancel, go to REQ at the pending target.
- HOLD: when ID_allow_in, clear buf_valid, fetch_pc+=4, go to REQ in the same cycle. Back-to-back: the request is asserted the cycle the buffer drains.
- IFreg_valid = buf_valid & ~redirect_valid. Minimum latency is 1 cycle from data_ok to IFreg_valid.
- At most one outstanding transaction. No request is issued while buf_valid=1 and the buffer is not draining.
- Redirect, which wins over every other event in the same cycle:
  - In IDLE/HOLD: fetch_pc←redirect_pc, buf_valid←0, go to REQ.
  - In REQ with no addr_ok: the request stays stable; set cancel=1 and store the target in pend_pc. Once addr_ok arrives, go to WAIT with the cancel still pending.
  - In REQ with addr_ok in the same cycle: set cancel=1, go to WAIT.
  - In WAIT without data_ok: set cancel=1 and store pend_pc.
  - In WAIT with data_ok in the same cycle: drop the data, go to REQ at redirect_pc, cancel=0.
  - A second redirect while cancel=1 overwrites pend_pc; only one response is dropped.
- ADEF: if the next fetch PC has [1:0]≠0, issue no request. Load the buffer directly with inst=0, pc=target, ebus[EBUS_ADEF]=1, go to HOLD. Hand-off is the same as a normal instruction.
- PC arithmetic is 32-bit; 32'hfffffffc+4 wraps to 0 with no error.
- An async reset mid-transaction abandons the transaction. Responses after reset are ignored: in IDLE, any data_ok is discarded.

Decomposition:
- Shared macro header: IFReg_BUS_LEN, EBUS_ADEF, RESET_PC, state encodings (IDLE=0, REQ=1, WAIT=2, HOLD=3).
- One natural sub-module, if_inst_buf: a 1-entry buffer with valid/inst/pc/ebus registers and fill/drain/flush controls. Everything else stays in if_fetch_ctrl.

Test Plan:
- Reset release, addr_ok=1 and data_ok 1 cycle later with rdata=32'h02800c0c, ID_allow_in=1 → req addr=32'h1c000000; IFreg_valid 1 cycle after data_ok with pc=32'h1c000000; next req addr=32'h1c000004.
- ID_allow_in=0 for 5 cycles after data_ok → IFreg_bus held constant; req=0 throughout; req for 32'h1c000004 asserted the cycle ID_allow_in rises.
- Redirect to 32'h1c008000 while in WAIT, data_ok 3 cycles later with rdata=32'hdeadbeef → data dropped, IFreg_valid stays 0; next req addr=32'h1c008000.
- addr_ok held 0 for 4 cycles, redirect to 32'h1c000100 in cycle 2 → addr stays 32'h1c000000 until addr_ok; that response is dropped; next fetch is 32'h1c000100.
- Redirect to 32'h1c000102 → no req issued; IFreg_valid=1 with pc=32'h1c000102, inst=0, ebus bit EBUS_ADEF=1.
- Assert reset while in WAIT, data_ok arrives during/after reset → all outputs return to reset values; stale data_ok ignored; fetch restarts at 32'h1c000000.
